// File: rtl/fc_window_buf_pkg.sv
// fc_window_buf_pkg
//   Shared definitions for the FC source-window buffer: command mode
//   encodings, FSM state encodings and a small clog2 helper.
package fc_window_buf_pkg;

    typedef enum logic {
        MODE_LOAD  = 1'b0,
        MODE_SHIFT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // window empty, fill == 0
        ST_PRIME  = 2'd1,   // partially filled by SHIFTs, never valid
        ST_STREAM = 2'd2    // window full
    } state_e;

    function automatic int fc_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/fc_window_buf_bank_mux.sv
// fc_bank_mux
//   Combinational group/bank selector for the window buffer.
//   sram_rdata : all bank words, group g bank b at [(g*BANK_NUM+b)*WORD_W +: WORD_W]
//   sel        : group index; out of range -> group_vec and word are zero, sel_bad=1
//   bank       : bank index inside the group; out of range -> word zero, bank_bad=1
//   group_vec  : the selected group's BANK_NUM words, bank 0 in LSBs
//   word       : the selected single bank word
module fc_bank_mux
    import fc_window_buf_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int BANK_NUM               = 5,
    parameter int GROUP_NUM              = 3,
    parameter int SEL_W                  = 2,
    parameter int BANK_W                 = 3
) (
    input  logic [GROUP_NUM*BANK_NUM*DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata,
    input  logic [SEL_W-1:0]                                               sel,
    input  logic [BANK_W-1:0]                                              bank,
    output logic [BANK_NUM*DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]          group_vec,
    output logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]                   word,
    output logic                                                           sel_bad,
    output logic                                                           bank_bad
);
    localparam int WORD_W = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH;
    localparam int WIN_W  = BANK_NUM * WORD_W;

    // Match-and-select loops keep every part-select in range, so an illegal
    // index simply falls through to the zero default.
    always_comb begin
        group_vec = '0;
        sel_bad   = 1'b1;
        for (int g = 0; g < GROUP_NUM; g++) begin
            if (sel == SEL_W'(g)) begin
                group_vec = sram_rdata[g*WIN_W +: WIN_W];
                sel_bad   = 1'b0;
            end
        end
    end

    // Word is picked from group_vec, so an illegal group also zeroes it.
    always_comb begin
        word     = '0;
        bank_bad = 1'b1;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (bank == BANK_W'(b)) begin
                word     = group_vec[b*WORD_W +: WORD_W];
                bank_bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fc_window_buf.sv
// fc_window_buf
//   Gathers SRAM read words from one bank group into a BANK_NUM-word window
//   for the FC MAC array. LOAD replaces the whole window, SHIFT slides in one
//   bank word at the top (priming from empty after a flush).
//   clk/rst     : clock, asynchronous active-high reset
//   sram_rdata  : all bank read words of all groups
//   in_valid/in_ready, in_mode, in_sel, in_bank : command handshake
//   flush       : synchronous clear of window, fill and err_sel
//   out_valid/out_ready, src_window : window handshake, bank word 0 in LSBs
//   fill        : valid words in window (0..BANK_NUM)
//   err_sel     : sticky flag, an accepted command used an illegal index
module fc_window_buf
    import fc_window_buf_pkg::*;
#(
    parameter int DATA_WIDTH             = 8,
    parameter int DATA_NUM_PER_SRAM_ADDR = 4,
    parameter int BANK_NUM               = 5,
    parameter int GROUP_NUM              = 3,
    parameter int SEL_W                  = 2,
    parameter int BANK_W                 = 3
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic [GROUP_NUM*BANK_NUM*DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata,
    input  logic                                                           in_valid,
    output logic                                                           in_ready,
    input  logic                                                           in_mode,
    input  logic [SEL_W-1:0]                                               in_sel,
    input  logic [BANK_W-1:0]                                              in_bank,
    input  logic                                                           flush,
    output logic                                                           out_valid,
    input  logic                                                           out_ready,
    output logic [BANK_NUM*DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0]          src_window,
    output logic [BANK_W-1:0]                                              fill,
    output logic                                                           err_sel
);
    localparam int WORD_W = DATA_NUM_PER_SRAM_ADDR * DATA_WIDTH;
    localparam int WIN_W  = BANK_NUM * WORD_W;
    localparam logic [BANK_W-1:0] FULL = BANK_W'(BANK_NUM);

    state_e              state;
    logic [WIN_W-1:0]    group_vec;
    logic [WORD_W-1:0]   new_word;
    logic                sel_bad;
    logic                bank_bad;
    logic                accept;
    logic                is_shift;
    logic [BANK_W-1:0]   shift_fill;
    logic                shift_full;

    fc_bank_mux #(
        .DATA_WIDTH             (DATA_WIDTH),
        .DATA_NUM_PER_SRAM_ADDR (DATA_NUM_PER_SRAM_ADDR),
        .BANK_NUM               (BANK_NUM),
        .GROUP_NUM              (GROUP_NUM),
        .SEL_W                  (SEL_W),
        .BANK_W                 (BANK_W)
    ) u_mux (
        .sram_rdata (sram_rdata),
        .sel        (in_sel),
        .bank       (in_bank),
        .group_vec  (group_vec),
        .word       (new_word),
        .sel_bad    (sel_bad),
        .bank_bad   (bank_bad)
    );

    // flush blocks acceptance so a same-cycle command is never half-applied.
    assign in_ready = ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign is_shift = (in_mode == MODE_SHIFT);

    // Saturating fill for SHIFT; the window is full once we are streaming or
    // this shift lands the last missing word.
    assign shift_full = (state == ST_STREAM) || (fill >= FULL - 1'b1);
    assign shift_fill = shift_full ? FULL : fill + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            src_window <= '0;
            out_valid  <= 1'b0;
            fill       <= '0;
            err_sel    <= 1'b0;
        end else if (flush) begin
            state      <= ST_IDLE;
            src_window <= '0;
            out_valid  <= 1'b0;
            fill       <= '0;
            err_sel    <= 1'b0;
        end else if (accept) begin
            if (is_shift) begin
                src_window <= {new_word, src_window[WIN_W-1:WORD_W]};
                fill       <= shift_fill;
                out_valid  <= shift_full;
                state      <= shift_full ? ST_STREAM : ST_PRIME;
                if (sel_bad || bank_bad) err_sel <= 1'b1;
            end else begin
                // in_bank is irrelevant for LOAD, so only the group is checked.
                src_window <= group_vec;
                fill       <= FULL;
                out_valid  <= 1'b1;
                state      <= ST_STREAM;
                if (sel_bad) err_sel <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_window_buf.sv
module tb_fc_window_buf;

    localparam int DW = 8, DN = 4, BN = 5, GN = 3, SW = 2, BW = 3;
    localparam int WORD_W = DN * DW;
    localparam int WIN_W  = BN * WORD_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [GN*WIN_W-1:0]      sram_rdata;
    logic                     in_valid, in_ready, in_mode, flush;
    logic [SW-1:0]            in_sel;
    logic [BW-1:0]            in_bank;
    logic                     out_valid, out_ready, err_sel;
    logic [WIN_W-1:0]         src_window;
    logic [BW-1:0]            fill;

    fc_window_buf #(
        .DATA_WIDTH(DW), .DATA_NUM_PER_SRAM_ADDR(DN), .BANK_NUM(BN),
        .GROUP_NUM(GN), .SEL_W(SW), .BANK_W(BW)
    ) dut (
        .clk(clk), .rst(rst), .sram_rdata(sram_rdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_sel(in_sel), .in_bank(in_bank), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .src_window(src_window), .fill(fill), .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rdy;
        logic [WIN_W-1:0] win;
        logic [BW-1:0]    fill;
        logic             vld;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    logic [WIN_W-1:0] m_win;
    int               m_fill;
    logic             m_vld, m_err;
    logic             obs_ready;

    function automatic logic [WORD_W-1:0] bank_word(input int g, input int b);
        logic [7:0] byt;
        if (g >= GN || b >= BN) return '0;
        byt = 8'((g << 4) + b);
        return {4{byt}};
    endfunction

    task automatic model_reset();
        m_win = '0; m_fill = 0; m_vld = 1'b0; m_err = 1'b0;
        sb.delete();
    endtask

    // Drives one cycle at the negedge, samples in_ready, advances the model
    // and queues the expected post-edge state.
    task automatic drive_cycle(input logic v, input logic mode, input int sel,
                               input int bank, input logic fl, input logic ordy);
        exp_t e;
        logic acc;
        @(negedge clk);
        in_valid = v; in_mode = mode; in_sel = SW'(sel); in_bank = BW'(bank);
        flush = fl; out_ready = ordy;
        #1;
        obs_ready = in_ready;
        e.rdy = !fl && (!m_vld || ordy);
        acc = v && e.rdy;
        if (fl) begin
            m_win = '0; m_fill = 0; m_vld = 1'b0; m_err = 1'b0;
        end else if (acc) begin
            if (mode == 1'b0) begin
                for (int b = 0; b < BN; b++) m_win[b*WORD_W +: WORD_W] = bank_word(sel, b);
                m_fill = BN; m_vld = 1'b1;
                if (sel >= GN) m_err = 1'b1;
            end else begin
                m_win = {bank_word(sel, bank), m_win[WIN_W-1:WORD_W]};
                m_fill = (m_fill + 1 > BN) ? BN : m_fill + 1;
                m_vld = (m_fill == BN);
                if (sel >= GN || bank >= BN) m_err = 1'b1;
            end
        end else if (m_vld && ordy) begin
            m_vld = 1'b0;
        end
        e.win = m_win; e.fill = BW'(m_fill); e.vld = m_vld; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_mode = 0; in_sel = 0; in_bank = 0;
        flush = 0; out_ready = 0;
        model_reset();
        #2;
        n_cmp++; if (src_window !== '0) begin n_bad++; $display("FAIL reset_win got %h want 0", src_window); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", out_valid); end
        n_cmp++; if (fill !== '0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", fill); end
        n_cmp++; if (err_sel !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_sel); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", in_ready); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_load();
        exp_t e;
        drive_cycle(1, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (obs_ready !== e.rdy) begin n_bad++; $display("FAIL load_rdy got %b want %b", obs_ready, e.rdy); end
        n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL load_win got %h want %h", src_window, e.win); end
        n_cmp++; if (src_window[31:0] !== 32'h10101010) begin n_bad++; $display("FAIL load_w0 got %h want 10101010", src_window[31:0]); end
        n_cmp++; if (src_window[159:128] !== 32'h14141414) begin n_bad++; $display("FAIL load_w4 got %h want 14141414", src_window[159:128]); end
        n_cmp++; if (fill !== e.fill || out_valid !== e.vld) begin n_bad++; $display("FAIL load_fv got %0d/%b want %0d/%b", fill, out_valid, e.fill, e.vld); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        // Held LOAD sel=2 with the consumer stalled, then released.
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 0, 2, 0, 0, (i == 2));
            e = sb.pop_front();
            n_cmp++; if (obs_ready !== e.rdy) begin n_bad++; $display("FAIL bp_rdy[%0d] got %b want %b", i, obs_ready, e.rdy); end
            n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL bp_win[%0d] got %h want %h", i, src_window, e.win); end
            n_cmp++; if (out_valid !== e.vld || fill !== e.fill) begin n_bad++; $display("FAIL bp_fv[%0d] got %b/%0d want %b/%0d", i, out_valid, fill, e.vld, e.fill); end
        end
        n_cmp++; if (src_window[31:0] !== 32'h20202020) begin n_bad++; $display("FAIL bp_w0 got %h want 20202020", src_window[31:0]); end
    endtask

    task automatic test_prime();
        exp_t e;
        drive_cycle(0, 0, 0, 0, 1, 1);
        e = sb.pop_front();
        n_cmp++; if (src_window !== e.win || fill !== e.fill || out_valid !== e.vld) begin n_bad++; $display("FAIL flush_state got %h/%0d/%b want %h/%0d/%b", src_window, fill, out_valid, e.win, e.fill, e.vld); end
        n_cmp++; if (obs_ready !== e.rdy) begin n_bad++; $display("FAIL flush_rdy got %b want %b", obs_ready, e.rdy); end
        for (int b = 0; b < BN; b++) begin
            drive_cycle(1, 1, 0, b, 0, 1);
            e = sb.pop_front();
            n_cmp++; if (fill !== e.fill) begin n_bad++; $display("FAIL prime_fill[%0d] got %0d want %0d", b, fill, e.fill); end
            n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL prime_vld[%0d] got %b want %b", b, out_valid, e.vld); end
            n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL prime_win[%0d] got %h want %h", b, src_window, e.win); end
        end
    endtask

    task automatic test_stream_shift();
        exp_t e;
        drive_cycle(1, 1, 2, 3, 0, 1);
        e = sb.pop_front();
        n_cmp++; if (obs_ready !== e.rdy) begin n_bad++; $display("FAIL stream_rdy got %b want %b", obs_ready, e.rdy); end
        n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL stream_win got %h want %h", src_window, e.win); end
        n_cmp++; if (src_window[159:128] !== 32'h23232323) begin n_bad++; $display("FAIL stream_top got %h want 23232323", src_window[159:128]); end
        n_cmp++; if (fill !== e.fill || out_valid !== e.vld) begin n_bad++; $display("FAIL stream_fv got %0d/%b want %0d/%b", fill, out_valid, e.fill, e.vld); end
        // Consumer takes the window with no new command: out_valid drops.
        drive_cycle(0, 0, 0, 0, 0, 1);
        e = sb.pop_front();
        n_cmp++; if (out_valid !== e.vld || src_window !== e.win) begin n_bad++; $display("FAIL drain got %b/%h want %b/%h", out_valid, src_window, e.vld, e.win); end
    endtask

    task automatic test_illegal();
        exp_t e;
        drive_cycle(1, 0, 3, 0, 0, 1);   // illegal group
        drive_cycle(1, 0, 1, 0, 0, 1);   // legal LOAD, err stays
        drive_cycle(1, 1, 0, 7, 0, 1);   // illegal bank -> zero word
        drive_cycle(1, 1, 2, 4, 0, 1);
        drive_cycle(0, 0, 0, 0, 1, 1);   // flush clears err
        for (int i = 0; i < 5; i++) begin
            e = sb.pop_front();
            // Only the last cycle's outputs are live; earlier entries are
            // checked by replaying via their ordering below.
            if (i == 4) begin
                n_cmp++; if (err_sel !== e.err) begin n_bad++; $display("FAIL ill_err_flush got %b want %b", err_sel, e.err); end
                n_cmp++; if (src_window !== e.win || fill !== e.fill) begin n_bad++; $display("FAIL ill_flush_state got %h/%0d want %h/%0d", src_window, fill, e.win, e.fill); end
            end
        end
        // Step-by-step with live checks.
        drive_cycle(1, 0, 3, 0, 0, 1);
        e = sb.pop_front();
        n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL ill_sel_win got %h want %h", src_window, e.win); end
        n_cmp++; if (err_sel !== 1'b1) begin n_bad++; $display("FAIL ill_sel_err got %b want 1", err_sel); end
        drive_cycle(1, 0, 1, 0, 0, 1);
        e = sb.pop_front();
        n_cmp++; if (err_sel !== e.err || src_window !== e.win) begin n_bad++; $display("FAIL ill_sticky got %b/%h want %b/%h", err_sel, src_window, e.err, e.win); end
        drive_cycle(1, 1, 0, 7, 0, 1);
        e = sb.pop_front();
        n_cmp++; if (src_window !== e.win || src_window[159:128] !== 32'h0) begin n_bad++; $display("FAIL ill_bank_win got %h want %h", src_window, e.win); end
        n_cmp++; if (err_sel !== e.err) begin n_bad++; $display("FAIL ill_bank_err got %b want %b", err_sel, e.err); end
        drive_cycle(0, 0, 0, 0, 1, 1);
        e = sb.pop_front();
        n_cmp++; if (err_sel !== 1'b0) begin n_bad++; $display("FAIL ill_clear got %b want 0", err_sel); end
    endtask

    task automatic test_reset_and_flush_race();
        exp_t e;
        drive_cycle(1, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (out_valid !== e.vld) begin n_bad++; $display("FAIL pre_rst_vld got %b want %b", out_valid, e.vld); end
        // Async reset pulse between edges with a pending command.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_sel = 2'd2;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || src_window !== '0 || fill !== '0) begin n_bad++; $display("FAIL mid_rst got %b/%h/%0d want 0/0/0", out_valid, src_window, fill); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_noacc got %b want 0", out_valid); end
        drive_cycle(1, 0, 1, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++; if (src_window !== e.win) begin n_bad++; $display("FAIL rst_reload got %h want %h", src_window, e.win); end
        // flush with a simultaneous command: command not taken.
        drive_cycle(1, 0, 2, 0, 1, 1);
        e = sb.pop_front();
        n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL race_rdy got %b want 0", obs_ready); end
        n_cmp++; if (src_window !== e.win || out_valid !== e.vld || fill !== e.fill) begin n_bad++; $display("FAIL race_state got %h/%b/%0d want %h/%b/%0d", src_window, out_valid, fill, e.win, e.vld, e.fill); end
    endtask

    initial begin
        for (int g = 0; g < GN; g++)
            for (int b = 0; b < BN; b++)
                sram_rdata[(g*BN+b)*WORD_W +: WORD_W] = bank_word(g, b);
        test_reset();
        test_load();
        test_backpressure();
        test_prime();
        test_stream_shift();
        test_illegal();
        test_reset_and_flush_race();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
